// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
// Round-robin grant, one operation in flight, and the result comes back
// on a shared response channel tagged with the requester id.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid[1:0], req_ready[1:0] per-requester request handshake
//   req0_a/b/op, req1_a/b/op      per-requester operands and opcode
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_result            owner and captured result of the response
//   alu_a/b/opcode                registered operands driven to the ALU
//   alu_result                    ALU result, valid ALU_LAT edges after issue
//
// state | meaning
// IDLE  | arbitrating; req_ready asserted toward the granted requester
// WAIT  | operation issued; down-counting ALU latency
// RESP  | result held on the response channel until rsp_ready
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          gnt;
  logic          accept;

  // On a tie the requester not served last wins.
  always_comb begin
    gnt = 1'b0;
    case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && req_valid != 2'b00)
      req_ready = gnt ? 2'b10 : 2'b01;
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= gnt ? req1_a  : req0_a;
            alu_b      <= gnt ? req1_b  : req0_b;
            alu_opcode <= gnt ? req1_op : req0_op;
            rsp_id     <= gnt;
            last_grant <= gnt;
            cnt        <= CW'(ALU_LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          // Terminal count is one edge after the ALU output settles,
          // so capture happens ALU_LAT+1 edges after the accept.
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_opcode;

  logic [1:0]  r3_valid = '0;
  logic [1:0]  r3_ready;
  logic [15:0] r3_a0 = '0, r3_b0 = '0, r3_a1 = '0, r3_b1 = '0;
  logic [3:0]  r3_op0 = '0, r3_op1 = '0;
  logic        r3_rsp_valid, r3_rsp_ready = 1'b0, r3_rsp_id;
  logic [15:0] r3_rsp_result, r3_alu_a, r3_alu_b, r3_alu_result;
  logic [3:0]  r3_alu_opcode;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result)
  );

  alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_ready(r3_ready),
    .req0_a(r3_a0), .req0_b(r3_b0), .req0_op(r3_op0),
    .req1_a(r3_a1), .req1_b(r3_b1), .req1_op(r3_op1),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_id(r3_rsp_id),
    .rsp_result(r3_rsp_result),
    .alu_a(r3_alu_a), .alu_b(r3_alu_b), .alu_opcode(r3_alu_opcode),
    .alu_result(r3_alu_result)
  );

  // Behavioural ALU: 2=add, 4=sub, 9=xor, 13=not A.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd2:    return a + b;
      4'd4:    return a - b;
      4'd9:    return a ^ b;
      4'd13:   return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0] m1 = '0;
  logic [15:0] p3_0 = '0, p3_1 = '0, p3_2 = '0;
  always @(posedge clk) begin
    m1   <= alu_f(alu_a, alu_b, alu_opcode);
    p3_0 <= alu_f(r3_alu_a, r3_alu_b, r3_alu_opcode);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign alu_result    = m1;
  assign r3_alu_result = p3_2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [15:0] a0, b0;
    logic [3:0]  op0;
    logic [15:0] a1, b1;
    logic [3:0]  op1;
    logic        exp_id;
    logic [15:0] exp_res;
    int          hold;
  } vec_t;

  vec_t vecs[7];

  // Entered and left at a negedge.
  task automatic run_vec(input vec_t t);
    logic [1:0]  other;
    logic [15:0] ea, eb;
    logic [3:0]  eop;
    int          n;
    other = t.exp_id ? 2'b01 : 2'b10;
    ea  = t.exp_id ? t.a1  : t.a0;
    eb  = t.exp_id ? t.b1  : t.b0;
    eop = t.exp_id ? t.op1 : t.op0;
    req_valid = t.v;
    req0_a = t.a0; req0_b = t.b0; req0_op = t.op0;
    req1_a = t.a1; req1_b = t.b1; req1_op = t.op1;
    rsp_ready = 1'b0;
    #1;
    chk("grant", {30'd0, req_ready}, t.exp_id ? 32'd2 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("alu_a", {16'd0, alu_a}, {16'd0, ea});
    chk("alu_b", {16'd0, alu_b}, {16'd0, eb});
    chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, eop});
    req_valid = other;
    #1;
    chk("wait_ready", {30'd0, req_ready}, 32'd0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin n = i; break; end
    end
    chk("latency", n, 32'd2);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, t.exp_id});
    chk("rsp_result", {16'd0, rsp_result}, {16'd0, t.exp_res});
    for (int i = 0; i < t.hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_id", {31'd0, rsp_id}, {31'd0, t.exp_id});
      chk("hold_result", {16'd0, rsp_result}, {16'd0, t.exp_res});
      chk("hold_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("regrant", {30'd0, req_ready}, {30'd0, other});
    chk("alu_a_held", {16'd0, alu_a}, {16'd0, ea});
    req_valid = 2'b00;
  endtask

  initial begin
    int          n;
    logic        seen;
    vecs[0] = '{2'b11, 16'h000A, 16'h0004, 4'd4, 16'hF0F0, 16'hFFFF, 4'd9, 1'b0, 16'h0006, 0};
    vecs[1] = '{2'b11, 16'h000A, 16'h0004, 4'd4, 16'hF0F0, 16'hFFFF, 4'd9, 1'b1, 16'h0F0F, 0};
    vecs[2] = '{2'b11, 16'h000A, 16'h0004, 4'd4, 16'hF0F0, 16'hFFFF, 4'd9, 1'b0, 16'h0006, 0};
    vecs[3] = '{2'b01, 16'h0003, 16'h0005, 4'd2, 16'h0000, 16'h0000, 4'd0, 1'b0, 16'h0008, 0};
    vecs[4] = '{2'b10, 16'h0000, 16'h0000, 4'd0, 16'hFFFF, 16'h0001, 4'd2, 1'b1, 16'h0000, 0};
    vecs[5] = '{2'b01, 16'h1234, 16'h0F0F, 4'd9, 16'h0000, 16'h0000, 4'd0, 1'b0, 16'h1D3B, 5};
    vecs[6] = '{2'b11, 16'h0003, 16'h0005, 4'd2, 16'h0000, 16'h0001, 4'd4, 1'b1, 16'hFFFF, 0};

    #2;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_result", {16'd0, rsp_result}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during WAIT: everything clears at once and the op is dropped.
    req_valid = 2'b10; req1_a = 16'h0007; req1_b = 16'h0001; req1_op = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("pre_rst_alu_a", {16'd0, alu_a}, 32'h0007);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_id", {31'd0, rsp_id}, 32'd0);
    chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("mid_rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("mid_rst_op", {28'd0, alu_opcode}, 32'd0);
    chk("mid_rst_result", {16'd0, rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", {31'd0, seen}, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("post_rst_tie", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;

    // ALU_LAT=3 instance.
    @(negedge clk);
    r3_valid = 2'b10; r3_a1 = 16'h00FF; r3_b1 = 16'h0000; r3_op1 = 4'd13;
    #1;
    chk("l3_grant", {30'd0, r3_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    r3_valid = 2'b00;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (r3_rsp_valid) begin n = i; break; end
    end
    chk("l3_latency", n, 32'd4);
    chk("l3_id", {31'd0, r3_rsp_id}, 32'd1);
    chk("l3_result", {16'd0, r3_rsp_result}, 32'h0000FF00);
    r3_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r3_rsp_ready = 1'b0;
    chk("l3_drop", {31'd0, r3_rsp_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
